// File: rtl/kevin_serial_detector.sv
// Serial MSB-first word assembler: collects W bits, reports each completed word
// and whether it belongs to the MASK match set, and counts matches (saturating).
module kevin_serial_detector #(
    parameter int                W     = 4,
    parameter logic [(1<<W)-1:0] MASK  = 16'h56E2,
    parameter int                CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             out_valid,
    output logic             out_match,
    output logic [W-1:0]     out_value,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy
);

    localparam int               CW       = $clog2(W);
    localparam logic [CW-1:0]    LAST_CNT = CW'(W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    bit_cnt_r;
    logic [W-1:0]     shift_r;
    logic             out_valid_r;
    logic             out_match_r;
    logic [W-1:0]     out_value_r;
    logic [CNT_W-1:0] match_cnt_r;
    logic             accept_s;
    logic             last_s;
    logic [W-1:0]     word_s;
    logic             word_match_s;

    // clear always wins over a presented bit, so a colliding bit is never accepted
    assign accept_s     = in_valid & ~clear;
    assign last_s       = accept_s & (bit_cnt_r == LAST_CNT);
    assign word_s       = {shift_r[W-2:0], in_bit};
    assign word_match_s = MASK[word_s];

    // Next-state logic: IDLE holds no bits, SHIFT holds 1..W-1 bits
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (clear || last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Shift register and bit counter; counter wraps to 0 on the W-th bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= {CW{1'b0}};
            shift_r   <= {W{1'b0}};
        end else if (clear) begin
            bit_cnt_r <= {CW{1'b0}};
            shift_r   <= {W{1'b0}};
        end else if (accept_s) begin
            shift_r <= word_s;
            if (last_s) begin
                bit_cnt_r <= {CW{1'b0}};
            end else begin
                bit_cnt_r <= bit_cnt_r + CW'(1);
            end
        end else begin
            bit_cnt_r <= bit_cnt_r;
            shift_r   <= shift_r;
        end
    end

    // Completion outputs and saturating match counter; out_value survives clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_match_r <= 1'b0;
            out_value_r <= {W{1'b0}};
            match_cnt_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            out_valid_r <= 1'b0;
            out_match_r <= 1'b0;
            out_value_r <= out_value_r;
            match_cnt_r <= {CNT_W{1'b0}};
        end else if (last_s) begin
            out_valid_r <= 1'b1;
            out_match_r <= word_match_s;
            out_value_r <= word_s;
            if (word_match_s && (match_cnt_r != CNT_MAX)) begin
                match_cnt_r <= match_cnt_r + CNT_W'(1);
            end else begin
                match_cnt_r <= match_cnt_r;
            end
        end else begin
            out_valid_r <= 1'b0;
            out_match_r <= 1'b0;
            out_value_r <= out_value_r;
            match_cnt_r <= match_cnt_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_match = out_match_r;
    assign out_value = out_value_r;
    assign match_cnt = match_cnt_r;
    assign busy      = (state_r == SHIFT);

endmodule

// File: doc/kevin_serial_detector.md
KEVIN_SERIAL_DETECTOR -- requirements
Module: kevin_serial_detector

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning the word width in bits (2 to 8).
REQ-002 The block SHALL have parameter MASK, default 16'h56E2, width 2^W, meaning the match set: bit k set means value k matches; the default set is {1,5,6,7,9,10,12,14}.
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning the width of the match counter.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-006 The block SHALL have port in_valid, input, 1 bit, qualifying in_bit this cycle.
REQ-007 The block SHALL have port in_bit, input, 1 bit, serial data, MSB first.
REQ-008 The block SHALL have port clear, input, 1 bit, synchronous abort of the partial word plus clear of match_cnt.
REQ-009 The block SHALL have port out_valid, output, 1 bit, a one-cycle pulse marking a completed word.
REQ-010 The block SHALL have port out_match, output, 1 bit, equal to MASK[out_value] while out_valid=1 and 0 otherwise.
REQ-011 The block SHALL have port out_value, output, W bits, the last completed word.
REQ-012 The block SHALL have port match_cnt, output, CNT_W bits, the number of matching words since reset or clear.
REQ-013 The block SHALL have port busy, output, 1 bit, high while a partial word (1 to W-1 bits) is held.

Function
REQ-014 The block SHALL implement a two-state FSM, IDLE (bit count 0) and SHIFT (bit count 1..W-1), with registered state.
- IDLE -> SHIFT on in_valid=1 & clear=0.
- SHIFT -> IDLE when the W-th bit is accepted or clear=1.
- Otherwise hold.
REQ-015 On each accepted bit (in_valid=1, clear=0) the block SHALL shift it into the LSB of a W-bit shift register, with the first-received bit ending in the MSB, and increment the bit counter.
REQ-016 When in_valid=0, the shift register, bit counter and state SHALL hold; gaps of any length between bits SHALL be allowed.
REQ-017 On the edge accepting the W-th bit, the block SHALL register the assembled word into out_value, set out_valid=1 and set out_match=MASK[word], all visible in the following cycle (latency 1 cycle after the last bit).
REQ-018 The bit counter SHALL return to 0 on that same edge, so a bit presented in the next cycle starts a new word; back-to-back words with no idle cycles SHALL be supported with out_valid pulsing once per word.
REQ-019 out_valid and out_match SHALL deassert in the cycle after the pulse unless another word completes on that edge.
REQ-020 out_value SHALL hold its value between completions.
REQ-021 match_cnt SHALL increment by 1 on the same edge that sets out_match=1.
REQ-022 match_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 When clear=1, the block SHALL:
- zero the bit counter, shift register and match_cnt;
- force out_valid=0 and out_match=0 next cycle;
- leave out_value unchanged.
REQ-024 clear SHALL take priority over in_valid in the same cycle: the bit is discarded and no word completes, even if it would have been the W-th bit.
REQ-025 busy SHALL be 1 exactly when the FSM is in SHIFT.
REQ-026 MASK bits SHALL be indexed by the unsigned value of the word; the block SHALL need no logic beyond 2^W entries.

Reset
REQ-027 When rst_n=0, the block SHALL immediately, without waiting for clk, force FSM=IDLE, bit count=0, shift register=0, out_valid=0, out_match=0, out_value=0, match_cnt=0 and busy=0.
REQ-028 Reset asserted mid-word SHALL discard the partial word; after release, the first accepted bit SHALL be treated as the MSB of a new word.
REQ-029 The block SHALL accept bits starting from the first rising clk edge after rst_n deasserts.

Verification
REQ-030 Exhaustive test, default parameters: serialise words 0..15 back-to-back -> out_valid pulses 16 times, once every 4 cycles, and out_match=1 exactly for 1,5,6,7,9,10,12,14; final match_cnt=8.
REQ-031 Gapped input: send 1,0,1,0 (value 10) with 3 idle cycles between bits -> a single out_valid pulse 1 cycle after the 4th bit, out_value=4'hA, out_match=1, busy=1 during the gaps.
REQ-032 Clear collision: send 3 bits of 0110, then assert clear together with the 4th bit -> no out_valid, busy=0 and match_cnt=0 next cycle; then send 0111 -> out_value=7, out_match=1.
REQ-033 Asynchronous reset: drop rst_n mid-clock after 2 bits -> all outputs 0 before the next edge; after release, send 0001 -> out_value=1, out_match=1, match_cnt=1.
REQ-034 Saturation: CNT_W=2, send value 5 five times -> match_cnt follows 1,2,3,3,3.
REQ-035 Parameter variant: W=3, MASK=8'h81 -> only values 0 and 7 match; value 3 gives out_valid=1 with out_match=0.
